// File: rtl/link_align_ctrl.sv
// Per-lane bring-up sequencer for the 64b/66b RX alignment path: holds the gearbox in reset,
// gates the aligner, qualifies frame lock and tracks link health and saturating statistics.
module link_align_ctrl #(
  parameter int RST_HOLD        = 16,
  parameter int MAX_SLIPS       = 66,
  parameter int LOCK_STABLE_CNT = 1024,
  parameter int BER_HOLD        = 4096
) (
  input  logic       clk_156mhz,
  input  logic       sys_reset,
  input  logic       opto_rdy,
  input  logic       slip,
  input  logic       frm_lock,
  input  logic       hi_ber,
  input  logic       clr_stats,
  output logic       channel_rdy,
  output logic       gb_reset,
  output logic       link_up,
  output logic [2:0] state,
  output logic [7:0] slip_cnt,
  output logic [7:0] drop_cnt
);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SEARCH   = 3'd2,
    ST_VERIFY   = 3'd3,
    ST_UP       = 3'd4
  } state_t;

  localparam logic [15:0] HOLD_LAST   = 16'(RST_HOLD - 1);
  localparam logic [15:0] SLIP_LAST   = 16'(MAX_SLIPS - 1);
  localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CNT - 1);
  localparam logic [15:0] BER_LAST    = 16'(BER_HOLD - 1);

  state_t      state_q, state_nxt;
  logic [15:0] hold_q, hold_nxt;
  logic [15:0] attempt_q, attempt_nxt;
  logic [15:0] stable_q, stable_nxt;
  logic [15:0] ber_q, ber_nxt;
  logic        slip_d;
  logic        slip_edge;
  logic        drop_evt;

  assign slip_edge = slip & ~slip_d;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state_q;
    hold_nxt    = 16'd0;
    attempt_nxt = attempt_q;
    stable_nxt  = stable_q;
    ber_nxt     = 16'd0;
    case (state_q)
      ST_RESET: begin
        attempt_nxt = 16'd0;
        if (hold_q == HOLD_LAST) state_nxt = ST_WAIT_RDY;
        else                     hold_nxt  = hold_q + 16'd1;
      end
      ST_WAIT_RDY: begin
        if (opto_rdy) state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
        // A slip seen in the same cycle as frame lock still counts toward the attempt budget.
        if (slip_edge) attempt_nxt = attempt_q + 16'd1;
        if (!opto_rdy) begin
          state_nxt = ST_WAIT_RDY;
        end else if (frm_lock) begin
          state_nxt  = ST_VERIFY;
          stable_nxt = 16'd0;
        end else if (slip_edge && attempt_q == SLIP_LAST) begin
          state_nxt = ST_RESET;
        end
      end
      ST_VERIFY: begin
        if (!opto_rdy) begin
          state_nxt = ST_WAIT_RDY;
        end else if (!frm_lock) begin
          state_nxt = ST_SEARCH;
        end else if (hi_ber) begin
          stable_nxt = 16'd0;
        end else if (stable_q == STABLE_LAST) begin
          state_nxt = ST_UP;
        end else begin
          stable_nxt = stable_q + 16'd1;
        end
      end
      ST_UP: begin
        if (hi_ber) ber_nxt = ber_q + 16'd1;
        if (!opto_rdy) begin
          state_nxt = ST_WAIT_RDY;
        end else if (hi_ber && ber_q == BER_LAST) begin
          state_nxt = ST_RESET;
        end else if (!frm_lock) begin
          state_nxt   = ST_SEARCH;
          attempt_nxt = 16'd0;
        end
      end
      default: state_nxt = ST_RESET;
    endcase
  end

  assign drop_evt = (state_q == ST_UP) && (state_nxt != ST_UP);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_156mhz) begin
    if (sys_reset) begin
      state_q   <= ST_RESET;
      hold_q    <= 16'd0;
      attempt_q <= 16'd0;
      stable_q  <= 16'd0;
      ber_q     <= 16'd0;
      slip_d    <= 1'b0;
      slip_cnt  <= 8'd0;
      drop_cnt  <= 8'd0;
    end else begin
      state_q   <= state_nxt;
      hold_q    <= hold_nxt;
      attempt_q <= attempt_nxt;
      stable_q  <= stable_nxt;
      ber_q     <= ber_nxt;
      slip_d    <= slip;
      if (clr_stats)                         slip_cnt <= 8'd0;
      else if (slip_edge && slip_cnt != 8'hFF) slip_cnt <= slip_cnt + 8'd1;
      if (clr_stats)                         drop_cnt <= 8'd0;
      else if (drop_evt && drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Outputs decode the state register only; illegal encodings drive everything inactive.
  assign state       = state_q;
  assign gb_reset    = (state_q == ST_RESET);
  assign channel_rdy = (state_q == ST_SEARCH) || (state_q == ST_VERIFY) || (state_q == ST_UP);
  assign link_up     = (state_q == ST_UP);

endmodule

// File: tb/tb_link_align_ctrl.sv
// Directed bench for link_align_ctrl: bring-up, slip exhaustion, VERIFY disturbances,
// BER handling in UP, simultaneous events, statistic saturation/clear and mid-run reset.
module tb_link_align_ctrl;

  logic       clk_156mhz = 1'b0;
  logic       sys_reset, opto_rdy, slip, frm_lock, hi_ber, clr_stats;
  logic       channel_rdy, gb_reset, link_up;
  logic [2:0] state;
  logic [7:0] slip_cnt, drop_cnt;

  int checks   = 0;
  int failures = 0;

  link_align_ctrl #(
    .RST_HOLD(16), .MAX_SLIPS(4), .LOCK_STABLE_CNT(8), .BER_HOLD(4)
  ) dut (
    .clk_156mhz (clk_156mhz),
    .sys_reset  (sys_reset),
    .opto_rdy   (opto_rdy),
    .slip       (slip),
    .frm_lock   (frm_lock),
    .hi_ber     (hi_ber),
    .clr_stats  (clr_stats),
    .channel_rdy(channel_rdy),
    .gb_reset   (gb_reset),
    .link_up    (link_up),
    .state      (state),
    .slip_cnt   (slip_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk_156mhz = ~clk_156mhz;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_156mhz);
      #1;
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int n = 0;
    while (state !== target && n < 200) begin
      step();
      n++;
    end
    check(tag, state, target);
  endtask

  task automatic count_gb_reset(input string tag);
    int cnt = 0;
    while (gb_reset === 1'b1 && cnt < 100) begin
      cnt++;
      step();
    end
    check(tag, cnt, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_reset = 1'b1; opto_rdy = 1'b1; slip = 1'b0;
    frm_lock  = 1'b0; hi_ber   = 1'b0; clr_stats = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_gb_reset", gb_reset, 1);
    check("rst_channel_rdy", channel_rdy, 0);
    check("rst_link_up", link_up, 0);
    check("rst_slip_cnt", slip_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);

    // 1. Bring-up
    sys_reset = 1'b0;
    count_gb_reset("t1_gb_reset_len");
    check("t1_wait_rdy", state, 1);
    step();
    check("t1_search", state, 2);
    check("t1_channel_rdy", channel_rdy, 1);
    step(4);
    check("t1_still_search", state, 2);
    frm_lock = 1'b1;
    step();
    check("t1_verify", state, 3);
    step(7);
    check("t1_verify_7", state, 3);
    check("t1_no_link_yet", link_up, 0);
    step();
    check("t1_up", state, 4);
    check("t1_link_up", link_up, 1);

    // 2. Slip exhaustion (drop to SEARCH first)
    frm_lock = 1'b0;
    step();
    check("t2_search", state, 2);
    check("t2_drop_cnt", drop_cnt, 1);
    slip = 1'b1;
    step(3);
    check("t2_held_slip_once", slip_cnt, 1);
    slip = 1'b0;
    step();
    for (int p = 0; p < 2; p++) begin
      slip = 1'b1; step();
      slip = 1'b0; step();
    end
    check("t2_after_3_edges", state, 2);
    slip = 1'b1;
    step();
    check("t2_reset_entered", state, 0);
    check("t2_slip_cnt", slip_cnt, 4);
    slip = 1'b0;
    count_gb_reset("t2_gb_reset_len");
    step();
    check("t2_back_search", state, 2);

    // 3. VERIFY disturbances
    frm_lock = 1'b1;
    step();
    check("t3_verify", state, 3);
    step(5);
    frm_lock = 1'b0;
    step();
    check("t3_lost_lock", state, 2);
    check("t3_no_link", link_up, 0);
    frm_lock = 1'b1;
    step(4);
    hi_ber = 1'b1;
    step();
    hi_ber = 1'b0;
    check("t3_ber_pulse_verify", state, 3);
    step(7);
    check("t3_not_up_7", state, 3);
    step();
    check("t3_up_8", state, 4);

    // 4. BER in UP
    hi_ber = 1'b1;
    step(3);
    hi_ber = 1'b0;
    step();
    check("t4_ber3_stays_up", state, 4);
    hi_ber = 1'b1;
    step(3);
    check("t4_ber3_up", link_up, 1);
    step();
    check("t4_ber4_reset", state, 0);
    check("t4_link_down", link_up, 0);
    check("t4_drop_cnt", drop_cnt, 2);
    hi_ber = 1'b0;

    // 5. Simultaneous exit conditions in UP
    wait_state("t5_reach_up", 3'd4);
    hi_ber = 1'b1;
    step(3);
    opto_rdy = 1'b0; frm_lock = 1'b0;
    step();
    check("t5_wait_rdy", state, 1);
    check("t5_drop_cnt", drop_cnt, 3);
    hi_ber = 1'b0;

    // 6. Saturation, clear priority, mid-VERIFY reset
    opto_rdy = 1'b1;
    for (int p = 0; p < 300; p++) begin
      slip = 1'b1; step();
      slip = 1'b0; step();
    end
    check("t6_slip_sat", slip_cnt, 255);
    check("t6_drop_hold", drop_cnt, 3);
    clr_stats = 1'b1; slip = 1'b1;
    step();
    check("t6_clr_slip", slip_cnt, 0);
    check("t6_clr_drop", drop_cnt, 0);
    clr_stats = 1'b0; slip = 1'b0;
    frm_lock = 1'b1;
    wait_state("t6_reach_verify", 3'd3);
    step(3);
    sys_reset = 1'b1;
    step();
    check("t6_sysrst_state", state, 0);
    check("t6_sysrst_gb_reset", gb_reset, 1);
    check("t6_sysrst_channel_rdy", channel_rdy, 0);
    sys_reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
